// File: rtl/vga_sync_controller.sv
// ---------------------------------------------------------------------------
// vga_sync_controller
//
// Timing master for the VGA output path. A clock divider produces a one-clk
// pixel enable. Two counters walk the raster (columns, then lines). The
// returned RGB332 pixel is registered together with the decoded sync and
// visibility flags, so colour and sync leave the block aligned with each
// other. All registered outputs lag the counters that produced them by one
// pixel.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   PixData      in   [7:0] RGB332 from the pattern generator, a function of
//                     Hcounter/Vcounter
//   Hcounter     out  [9:0] current pixel column, 0..H_TOTAL-1
//   Vcounter     out  [9:0] current line, 0..V_TOTAL-1
//   pix_tick     out  one-clk pixel-rate enable, gated by rst
//   frame_start  out  one-clk pulse on the tick that wraps the raster to (0,0)
//   Hsync        out  horizontal sync, active low, registered
//   Vsync        out  vertical sync, active low, registered
//   video_on     out  registered pixel lies in the visible area
//   Red          out  [2:0] PixData[7:5] when visible, else 0
//   Green        out  [2:0] PixData[4:2] when visible, else 0
//   Blue         out  [1:0] PixData[1:0] when visible, else 0
// ---------------------------------------------------------------------------
module vga_sync_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] PixData,
  output logic [9:0] Hcounter,
  output logic [9:0] Vcounter,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       Hsync,
  output logic       Vsync,
  output logic       video_on,
  output logic [2:0] Red,
  output logic [2:0] Green,
  output logic [1:0] Blue
);

  // -------------------------------------------------------------------------
  // Derived timing constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide-by-one divider still needs a one-bit register; it simply stays 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // Pixel-rate divider
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_raw;

  always_comb begin
    div_d = div_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Registers below are held by reset directly, so the ungated tick is safe
  // to use internally; only the exported copy needs the rst gate (with
  // CLK_DIV=1 the raw tick is constantly high).
  assign tick_raw = (div_q == DIV_LAST);
  assign pix_tick = tick_raw & ~rst;

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick_raw) begin
      if (h_wrap) begin
        h_d = '0;
        // Both counters move on the same edge at the end of a line, so the
        // (H_LAST, V_LAST) -> (0, 0) wrap shows no intermediate value.
        if (v_wrap) begin
          v_d = '0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign Hcounter    = h_q;
  assign Vcounter    = v_q;
  assign frame_start = pix_tick & h_wrap & v_wrap;

  // -------------------------------------------------------------------------
  // Raster decode for the current counter position
  // -------------------------------------------------------------------------
  logic visible;
  logic hs_n;
  logic vs_n;

  assign visible = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hs_n    = ~((h_q >= H_SYNC_BEGIN) && (h_q < H_SYNC_END));
  assign vs_n    = ~((v_q >= V_SYNC_BEGIN) && (v_q < V_SYNC_END));

  // -------------------------------------------------------------------------
  // Output stage
  //
  // PixData is the pattern generator's answer for the current counters. It
  // is captured on the same tick edge as the sync/visibility decode of those
  // counters, which keeps colour and sync aligned one pixel behind the
  // counters. Between ticks every output holds.
  // -------------------------------------------------------------------------
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       von_q,   von_d;
  logic [7:0] rgb_q,   rgb_d;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    von_d   = von_q;
    rgb_d   = rgb_q;
    if (tick_raw) begin
      hsync_d = hs_n;
      vsync_d = vs_n;
      von_d   = visible;
      rgb_d   = visible ? PixData : 8'h00;
    end
  end

  // Sync idles high under reset so a pulse in progress is cut off at once
  // rather than stretched across the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      von_q   <= 1'b0;
      rgb_q   <= 8'h00;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      rgb_q   <= rgb_d;
    end
  end

  assign Hsync    = hsync_q;
  assign Vsync    = vsync_q;
  assign video_on = von_q;
  assign Red      = rgb_q[7:5];
  assign Green    = rgb_q[4:2];
  assign Blue     = rgb_q[1:0];

endmodule

// File: tb/tb_vga_sync_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_controller
//
// Three instances run side by side from one clock and one reset:
//   a: default 640x480 timing, CLK_DIV=2
//   b: tiny raster (20x13), CLK_DIV=3, so whole frames fit in a short run
//   c: tiny raster (8x6), CLK_DIV=1
// Expected outputs come from the raster arithmetic: after k clock edges since
// reset release, t = k / CLK_DIV pixels have elapsed; the counters show pixel
// t and the registered outputs show pixel t-1.
// ---------------------------------------------------------------------------
module tb_vga_sync_controller;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       tick;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       von;
    logic [7:0] rgb;
  } obs_t;

  typedef struct packed {
    int d;
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
  } cfg_t;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int k = 0;        // clock edges since reset release
  int mode = 0;     // pattern generator selection
  int seed = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  int checks = 0;
  int errors = 0;

  // -------------------------------------------------------------------------
  // Pattern generator (shared by DUT stimulus and model)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] pat(input int m, input int sd, input int h, input int v);
    logic [7:0] p;
    case (m)
      0: p = 8'hFF;
      1: p = 8'hE0;
      2: begin
        case ((h / 80) % 3)
          0:       p = 8'h03;  // blue
          1:       p = 8'h1C;  // green
          default: p = 8'hE0;  // red
        endcase
      end
      default: p = 8'((h * 37) ^ (v * 101) ^ sd);
    endcase
    return p;
  endfunction

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    case (i)
      0:       c = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
      1:       c = '{3, 10, 2, 3, 5, 6, 2, 2, 3};
      default: c = '{1, 4, 1, 2, 1, 3, 1, 1, 1};
    endcase
    return c;
  endfunction

  // Behavioural model: outputs after k edges since release.
  function automatic obs_t model(input cfg_t c, input int kk, input logic r,
                                 input int m, input int sd);
    obs_t e;
    int ht, vt, tot, t, pos, prv, ph, pv;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (r) return e;
    ht  = c.ha + c.hf + c.hsw + c.hb;
    vt  = c.va + c.vf + c.vsw + c.vb;
    tot = ht * vt;
    t   = kk / c.d;
    pos = t % tot;
    e.h    = 10'(pos % ht);
    e.v    = 10'(pos / ht);
    e.tick = ((kk % c.d) == c.d - 1);
    e.fs   = e.tick && (pos == tot - 1);
    if (t > 0) begin
      prv   = (t - 1) % tot;
      ph    = prv % ht;
      pv    = prv / ht;
      e.hs  = !((ph >= c.ha + c.hf) && (ph < c.ha + c.hf + c.hsw));
      e.vs  = !((pv >= c.va + c.vf) && (pv < c.va + c.vf + c.vsw));
      e.von = (ph < c.ha) && (pv < c.va);
      e.rgb = e.von ? pat(m, sd, ph, pv) : 8'h00;
    end
    return e;
  endfunction

  // -------------------------------------------------------------------------
  // DUTs
  // -------------------------------------------------------------------------
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic       tick_a, fs_a, hs_a, vs_a, von_a;
  logic       tick_b, fs_b, hs_b, vs_b, von_b;
  logic       tick_c, fs_c, hs_c, vs_c, von_c;
  logic [2:0] r_a, g_a, r_b, g_b, r_c, g_c;
  logic [1:0] b_a, b_b, b_c;
  logic [7:0] pix_a, pix_b, pix_c;

  always_comb pix_a = pat(mode, seed, int'(h_a), int'(v_a));
  always_comb pix_b = pat(mode, seed, int'(h_b), int'(v_b));
  always_comb pix_c = pat(mode, seed, int'(h_c), int'(v_c));

  vga_sync_controller u_a (
    .clk(clk), .rst(rst), .PixData(pix_a), .Hcounter(h_a), .Vcounter(v_a),
    .pix_tick(tick_a), .frame_start(fs_a), .Hsync(hs_a), .Vsync(vs_a),
    .video_on(von_a), .Red(r_a), .Green(g_a), .Blue(b_a)
  );

  vga_sync_controller #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .clk(clk), .rst(rst), .PixData(pix_b), .Hcounter(h_b), .Vcounter(v_b),
    .pix_tick(tick_b), .frame_start(fs_b), .Hsync(hs_b), .Vsync(vs_b),
    .video_on(von_b), .Red(r_b), .Green(g_b), .Blue(b_b)
  );

  vga_sync_controller #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_c (
    .clk(clk), .rst(rst), .PixData(pix_c), .Hcounter(h_c), .Vcounter(v_c),
    .pix_tick(tick_c), .frame_start(fs_c), .Hsync(hs_c), .Vsync(vs_c),
    .video_on(von_c), .Red(r_c), .Green(g_c), .Blue(b_c)
  );

  obs_t obs [3];
  always_comb begin
    obs[0] = {h_a, v_a, tick_a, fs_a, hs_a, vs_a, von_a, r_a, g_a, b_a};
    obs[1] = {h_b, v_b, tick_b, fs_b, hs_b, vs_b, von_b, r_b, g_b, b_b};
    obs[2] = {h_c, v_c, tick_c, fs_c, hs_c, vs_c, von_c, r_c, g_c, b_c};
  end

  // -------------------------------------------------------------------------
  // Scoreboard: every negedge, each instance against the model
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      obs_t e;
      e = model(cfg_of(i), k, rst, mode, seed);
      checks = checks + 1;
      if (obs[i] !== e) begin
        errors = errors + 1;
        $display("FAIL cmp_inst%0d k=%0d got h=%0d v=%0d tick=%b fs=%b hs=%b vs=%b von=%b rgb=%h expected h=%0d v=%0d tick=%b fs=%b hs=%b vs=%b von=%b rgb=%h",
                 i, k, obs[i].h, obs[i].v, obs[i].tick, obs[i].fs, obs[i].hs, obs[i].vs,
                 obs[i].von, obs[i].rgb, e.h, e.v, e.tick, e.fs, e.hs, e.vs, e.von, e.rgb);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Edge monitors for timing measurements (cleared by reset)
  // -------------------------------------------------------------------------
  int   hs_f1 = -1, hs_f2 = -1, hs_r1 = -1;
  int   vs_f1 = -1, vs_r1 = -1;
  int   fsb_1 = -1, fsb_2 = -1, fsb_cnt = 0;
  int   fsc_1 = -1, fsc_2 = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      hs_f1 <= -1; hs_f2 <= -1; hs_r1 <= -1;
      vs_f1 <= -1; vs_r1 <= -1;
      fsb_1 <= -1; fsb_2 <= -1; fsb_cnt <= 0;
      fsc_1 <= -1; fsc_2 <= -1;
      hs_prev <= 1'b1; vs_prev <= 1'b1;
    end else begin
      if (hs_prev && !hs_a) begin
        if (hs_f1 < 0)      hs_f1 <= k;
        else if (hs_f2 < 0) hs_f2 <= k;
      end
      if (!hs_prev && hs_a && hs_r1 < 0) hs_r1 <= k;
      if (vs_prev && !vs_b && vs_f1 < 0) vs_f1 <= k;
      if (!vs_prev && vs_b && vs_r1 < 0) vs_r1 <= k;
      if (fs_b) begin
        fsb_cnt <= fsb_cnt + 1;
        if (fsb_1 < 0)      fsb_1 <= k;
        else if (fsb_2 < 0) fsb_2 <= k;
      end
      if (fs_c) begin
        if (fsc_1 < 0)      fsc_1 <= k;
        else if (fsc_2 < 0) fsc_2 <= k;
      end
      hs_prev <= hs_a;
      vs_prev <= vs_b;
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic chk(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Advance to the negedge at which k == n (at least one negedge).
  task automatic step_to(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (k < n && guard < 100000);
    if (k != n) chk("step_to", k, n);
  endtask

  // Asynchronous reset pulse: asserted off the clock edge, checked before
  // any further edge, released off the edge after len clocks.
  task automatic do_reset(input int m, input int sd, input int off, input int len);
    @(posedge clk);
    #(off);
    rst  = 1'b1;
    mode = m;
    seed = sd;
    #1;
    chk("rst_async_h", int'(h_a), 0);
    chk("rst_async_v", int'(v_a), 0);
    chk("rst_async_hsync", int'(hs_a), 1);
    chk("rst_async_rgb", int'({r_a, g_a, b_a}), 0);
    chk("rst_async_tick_div1", int'(tick_c), 0);
    repeat (len) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #5_000_000;
    errors = errors + 1;
    $display("FAIL watchdog k=%0d expected end of test", k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    obs_t m;
    int   wait_cnt;

    // Hand-computed pins on the model itself (default timing, CLK_DIV=2).
    m = model(cfg_of(0), 2, 1'b0, 0, 0);      chk("model_h_k2", int'(m.h), 1);
    m = model(cfg_of(0), 4, 1'b0, 0, 0);      chk("model_h_k4", int'(m.h), 2);
    m = model(cfg_of(0), 1313, 1'b0, 0, 0);   chk("model_hs_k1313", int'(m.hs), 1);
    m = model(cfg_of(0), 1314, 1'b0, 0, 0);   chk("model_hs_k1314", int'(m.hs), 0);
    m = model(cfg_of(0), 1505, 1'b0, 0, 0);   chk("model_hs_k1505", int'(m.hs), 0);
    m = model(cfg_of(0), 1506, 1'b0, 0, 0);   chk("model_hs_k1506", int'(m.hs), 1);
    m = model(cfg_of(0), 839999, 1'b0, 0, 0);
    chk("model_fs_wrap", int'(m.fs), 1);
    chk("model_h_last", int'(m.h), 799);
    chk("model_v_last", int'(m.v), 524);
    m = model(cfg_of(0), 840000, 1'b0, 0, 0);
    chk("model_h_zero", int'(m.h), 0);
    chk("model_v_zero", int'(m.v), 0);
    m = model(cfg_of(1), 482, 1'b0, 0, 0);    chk("model_vs_sm_482", int'(m.vs), 1);
    m = model(cfg_of(1), 483, 1'b0, 0, 0);    chk("model_vs_sm_483", int'(m.vs), 0);

    // Phase 1: reset release with PixData = FF, line and frame timing.
    mode = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    step_to(0);
    chk("p1_k0_h", int'(h_a), 0);
    chk("p1_k0_tick", int'(tick_a), 0);
    chk("p1_k0_hsync", int'(hs_a), 1);
    chk("p1_k0_tick_div1", int'(tick_c), 1);
    step_to(1);
    chk("p1_k1_tick", int'(tick_a), 1);
    chk("p1_k1_h", int'(h_a), 0);
    chk("p1_k1_von", int'(von_a), 0);
    chk("p1_k1_rgb", int'({r_a, g_a, b_a}), 0);
    step_to(2);
    chk("p1_k2_h", int'(h_a), 1);
    chk("p1_k2_tick", int'(tick_a), 0);
    chk("p1_k2_rgb", int'({r_a, g_a, b_a}), 8'hFF);
    step_to(4);
    chk("p1_k4_h", int'(h_a), 2);
    step_to(3400);
    chk("hsync_fall_k", hs_f1, 1314);
    chk("hsync_low_clk", hs_r1 - hs_f1, 192);
    chk("line_period_clk", hs_f2 - hs_f1, 1600);
    chk("vsync_fall_k_sm", vs_f1, 483);
    chk("vsync_low_clk_sm", vs_r1 - vs_f1, 120);
    chk("frame_start_first_sm", fsb_1, 779);
    chk("frame_period_sm", fsb_2 - fsb_1, 780);
    chk("frame_start_count_sm", fsb_cnt, 4);
    chk("frame_start_first_div1", fsc_1, 47);
    chk("frame_period_div1", fsc_2 - fsc_1, 48);

    // Phase 2: asynchronous reset in the middle of an Hsync pulse, then the
    // column-stripe pattern to check pipeline alignment.
    wait_cnt = 0;
    while (h_a != 10'd700 && wait_cnt < 2000) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("p2_reach_h700", int'(h_a), 700);
    chk("p2_hsync_low_before_rst", int'(hs_a), 0);
    do_reset(2, 0, 3, 3);
    step_to(2);
    chk("p2_k2_h", int'(h_a), 1);
    step_to(4);
    chk("p2_k4_h", int'(h_a), 2);
    step_to(161);
    chk("p2_rgb_h79_blue", int'({r_a, g_a, b_a}), 8'h03);
    step_to(162);
    chk("p2_rgb_h80_green", int'({r_a, g_a, b_a}), 8'h1C);
    step_to(1280);
    chk("p2_von_h639", int'(von_a), 1);
    step_to(1282);
    chk("p2_von_h640", int'(von_a), 0);
    chk("p2_rgb_h640", int'({r_a, g_a, b_a}), 0);

    // Phase 3: solid red, blanking over a full line and several small frames.
    do_reset(1, 0, 1, 2);
    step_to(2);
    chk("p3_red_visible", int'(r_a), 7);
    chk("p3_von_visible", int'(von_a), 1);
    step_to(1290);
    chk("p3_red_blank", int'(r_a), 0);
    step_to(2000);

    // Phase 4: randomized patterns, reset offsets/lengths and run lengths.
    for (int it = 0; it < 8; it++) begin
      do_reset($urandom_range(0, 3), $urandom_range(0, 255),
               $urandom_range(1, 3), $urandom_range(1, 4));
      step_to($urandom_range(200, 3000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
